// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   sram_state_e           : state of the SRAM wait tracker
//   REG_ZERO               : hard-wired zero register, never a real dependency
//   DEFAULT_TIMEOUT_CYCLES : default WAIT budget before the access is declared hung
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } sram_state_e;

  localparam logic [4:0] REG_ZERO               = 5'd0;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/sram_wait_fsm.sv
// Tracks an outstanding external SRAM access and freezes the pipeline while it
// is pending. Declares the access hung after TIMEOUT_CYCLES WAIT cycles.
// Ports:
//   clk, rst          : clock, async active-high reset
//   mem_req           : MEM stage has a load/store pending
//   sram_ready        : SRAM controller finished the current access
//   global_freeze     : combinational, hold every pipeline register
//   sram_timeout      : registered sticky hang flag
//
// state | meaning
// IDLE  | no access outstanding; a request without ready starts a wait
// WAIT  | access outstanding, pipeline frozen until sram_ready
// ERR   | access hung; pipeline frozen until reset
module sram_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic sram_ready,
  output logic global_freeze,
  output logic sram_timeout
);

  localparam int RW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RW-1:0] LOAD_VAL = RW'(TIMEOUT_CYCLES - 1);

  sram_state_e   state_q, state_d;
  // Remaining WAIT cycles before the hang is declared: it is loaded on WAIT
  // entry (the first WAIT cycle is WAIT cycle 1) and hits zero on WAIT
  // cycle TIMEOUT_CYCLES.
  logic [RW-1:0] remain_q, remain_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    state_d       = state_q;
    remain_d      = remain_q;
    global_freeze = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req && !sram_ready) begin
          state_d       = WAIT;
          remain_d      = LOAD_VAL;
          global_freeze = 1'b1;
        end
      end
      WAIT: begin
        if (sram_ready) begin
          state_d  = IDLE;
          remain_d = '0;
        end else begin
          global_freeze = 1'b1;
          if (remain_q == '0) begin
            state_d = ERR;
          end else begin
            remain_d = remain_q - RW'(1);
          end
        end
      end
      ERR: begin
        global_freeze = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    timeout_d = timeout_q | (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      timeout_q <= timeout_d;
    end
  end

  assign sram_timeout = timeout_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage SRAM pipeline.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   forward_en                    : forwarding active, only load-use stalls
//   id_src1/id_src2/id_two_src    : ID-stage sources
//   exe_dst/exe_wb_en/exe_mem_read: EX-stage destination info
//   mem_dst/mem_wb_en             : MEM-stage destination info
//   branch_taken                  : EX resolved a taken branch
//   mem_req/sram_ready            : SRAM access handshake
//   if_freeze/if_flush/id_flush   : stage-register controls (combinational)
//   global_freeze                 : freeze everything (combinational)
//   sram_timeout                  : sticky hang flag (registered)
//   stall_cnt                     : saturating hazard-stall count (registered)
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       exe_dst,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [4:0]       mem_dst,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             global_freeze,
  output logic             sram_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             raw1, raw2, lu1, lu2, hazard, stall_active;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  sram_wait_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_sram_wait_fsm (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .sram_ready   (sram_ready),
    .global_freeze(global_freeze),
    .sram_timeout (sram_timeout)
  );

  always_comb begin
    raw1 = (id_src1 != REG_ZERO) &&
           ((id_src1 == exe_dst && exe_wb_en) || (id_src1 == mem_dst && mem_wb_en));
    raw2 = id_two_src && (id_src2 != REG_ZERO) &&
           ((id_src2 == exe_dst && exe_wb_en) || (id_src2 == mem_dst && mem_wb_en));
    // With forwarding, only a load in EX cannot be bypassed in time.
    lu1  = (id_src1 != REG_ZERO) && (id_src1 == exe_dst) && exe_mem_read && exe_wb_en;
    lu2  = id_two_src && (id_src2 != REG_ZERO) && (id_src2 == exe_dst) &&
           exe_mem_read && exe_wb_en;
    hazard = forward_en ? (lu1 || lu2) : (raw1 || raw2);
  end

  // A frozen EX keeps the branch/hazard alive, so they are simply re-evaluated
  // once the freeze drops.
  always_comb begin
    if_freeze    = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    stall_active = 1'b0;
    if (global_freeze) begin
      if_freeze = 1'b1;
    end else if (branch_taken) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (hazard) begin
      if_freeze    = 1'b1;
      id_flush     = 1'b1;
      stall_active = 1'b1;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall_active && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int TMO   = 15;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic forward_en, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic branch_taken, mem_req, sram_ready;
  logic [4:0] id_src1, id_src2, exe_dst, mem_dst;
  logic if_freeze, if_flush, id_flush, global_freeze, sram_timeout;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: consecutive frozen cycles of the current access, hang flag,
  // expected stall count.
  int m_pending = 0;
  bit m_err     = 1'b0;
  int m_cnt     = 0;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dst(exe_dst), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dst(mem_dst), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready),
    .if_freeze(if_freeze), .if_flush(if_flush), .id_flush(id_flush),
    .global_freeze(global_freeze), .sram_timeout(sram_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    bit s1, s2;
    if (forward_en) begin
      s1 = id_src1 != 0 && id_src1 == exe_dst && exe_mem_read && exe_wb_en;
      s2 = id_two_src && id_src2 != 0 && id_src2 == exe_dst && exe_mem_read && exe_wb_en;
    end else begin
      s1 = id_src1 != 0 && ((id_src1 == exe_dst && exe_wb_en) || (id_src1 == mem_dst && mem_wb_en));
      s2 = id_two_src && id_src2 != 0 &&
           ((id_src2 == exe_dst && exe_wb_en) || (id_src2 == mem_dst && mem_wb_en));
    end
    return s1 || s2;
  endfunction

  function automatic bit m_freeze();
    if (m_err) return 1'b1;
    if (m_pending > 0) return !sram_ready;
    return mem_req && !sram_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending = 0;
      m_err     = 1'b0;
      m_cnt     = 0;
    end else begin
      if (!m_freeze() && !branch_taken && m_hazard() && m_cnt < CMAX) m_cnt++;
      if (!m_err) begin
        if (m_freeze()) begin
          m_pending++;
          if (m_pending > TMO) m_err = 1'b1;
        end else begin
          m_pending = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit f, h;
    f = m_freeze();
    h = m_hazard();
    chk("global_freeze", int'(global_freeze), int'(f));
    chk("if_freeze", int'(if_freeze), int'(f || (!branch_taken && h)));
    chk("if_flush", int'(if_flush), int'(!f && branch_taken));
    chk("id_flush", int'(id_flush), int'(!f && (branch_taken || h)));
    chk("sram_timeout", int'(sram_timeout), int'(m_err));
    chk("stall_cnt", int'(stall_cnt), m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    forward_en = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; sram_ready = 0;
    id_src1 = 0; id_src2 = 0; exe_dst = 0; mem_dst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_in();
    tick(); tick();
    @(negedge clk);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_timeout", int'(sram_timeout), 0);
    chk("rst_freeze", int'(global_freeze), 0);
    tick();
    rst = 1'b0;

    // Plain RAW hazard, no forwarding
    id_src1 = 5; exe_dst = 5; exe_wb_en = 1;
    @(negedge clk);
    chk("raw_if_freeze", int'(if_freeze), 1);
    chk("raw_id_flush", int'(id_flush), 1);
    chk("raw_cnt_before", int'(stall_cnt), 0);
    tick();
    clear_in();
    @(negedge clk);
    chk("raw_cnt_after", int'(stall_cnt), 1);
    tick();

    // Forwarding: only load-use stalls
    forward_en = 1; id_src1 = 5; exe_dst = 5; exe_wb_en = 1; exe_mem_read = 0;
    @(negedge clk);
    chk("fwd_no_load", int'(if_freeze), 0);
    tick();
    exe_mem_read = 1;
    @(negedge clk);
    chk("fwd_load_use", int'(if_freeze), 1);
    tick();
    exe_mem_read = 0;
    @(negedge clk);
    chk("fwd_bubble_done", int'(if_freeze), 0);
    tick();
    id_src1 = 0; exe_dst = 0; exe_mem_read = 1;
    @(negedge clk);
    chk("fwd_zero_reg", int'(if_freeze), 0);
    tick();
    clear_in();
    @(negedge clk);
    chk("fwd_cnt", int'(stall_cnt), 2);
    tick();

    // Second source only counts when id_two_src
    id_src1 = 3; id_src2 = 7; mem_dst = 7; mem_wb_en = 1;
    @(negedge clk);
    chk("src2_ignored", int'(if_freeze), 0);
    tick();
    id_two_src = 1;
    @(negedge clk);
    chk("src2_used", int'(if_freeze), 1);
    tick();
    clear_in();

    // Branch beats hazard
    id_src1 = 5; exe_dst = 5; exe_wb_en = 1; branch_taken = 1;
    @(negedge clk);
    chk("br_if_flush", int'(if_flush), 1);
    chk("br_id_flush", int'(id_flush), 1);
    chk("br_if_freeze", int'(if_freeze), 0);
    tick();
    clear_in();
    @(negedge clk);
    chk("br_cnt", int'(stall_cnt), 3);
    tick();

    // SRAM wait for 5 cycles with a masked branch; mem_req drops mid-wait
    mem_req = 1; branch_taken = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wait_freeze", int'(global_freeze), 1);
      chk("wait_br_masked", int'(if_flush), 0);
      tick();
      if (i == 1) mem_req = 0;
    end
    sram_ready = 1;
    @(negedge clk);
    chk("ready_release", int'(global_freeze), 0);
    chk("ready_branch", int'(if_flush), 1);
    tick();
    branch_taken = 0; mem_req = 1;
    @(negedge clk);
    chk("req_and_ready", int'(global_freeze), 0);
    tick();
    clear_in();

    // Timeout: ready low for 16 cycles, hazard present but frozen out
    mem_req = 1; id_src1 = 5; exe_dst = 5; exe_wb_en = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tmo_timeout_low", int'(sram_timeout), 0);
      tick();
    end
    @(negedge clk);
    chk("tmo_flag", int'(sram_timeout), 1);
    chk("tmo_freeze", int'(global_freeze), 1);
    chk("tmo_cnt", int'(stall_cnt), 3);
    tick();
    sram_ready = 1;
    @(negedge clk);
    chk("err_stuck", int'(global_freeze), 1);
    tick();
    rst = 1; clear_in();
    @(negedge clk);
    chk("err_rst_flag", int'(sram_timeout), 0);
    chk("err_rst_cnt", int'(stall_cnt), 0);
    chk("err_rst_freeze", int'(global_freeze), 0);
    chk("err_rst_if_freeze", int'(if_freeze), 0);
    tick();
    rst = 0;

    // Saturation of the stall counter
    id_src1 = 9; mem_dst = 9; mem_wb_en = 1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("sat_cnt", int'(stall_cnt), CMAX);
    tick();
    clear_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage SRAM pipeline. It drives the freeze and flush inputs of the IF/ID and ID/EX stage registers. It detects RAW hazards between the ID-stage sources and the EX/MEM destinations, squashes wrong-path instructions on taken branches, and freezes the whole pipeline while the external SRAM access is outstanding. It also keeps a saturating stall-cycle counter and a sticky SRAM-timeout flag for debug.

## Interface
Parameters:
- TIMEOUT_CYCLES, 15: maximum number of WAIT cycles before the SRAM access is declared hung.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- forward_en  in  1  forwarding unit active; relaxes the hazard rule
- id_src1, id_src2  in  5 each  register sources of the instruction in ID
- id_two_src  in  1  id_src2 is a real source
- exe_dst  in  5  EX-stage destination
- exe_wb_en  in  1  EX-stage write-back enable
- exe_mem_read  in  1  EX-stage instruction is a load
- mem_dst  in  5  MEM-stage destination
- mem_wb_en  in  1  MEM-stage write-back enable
- branch_taken  in  1  EX resolved a taken branch
- mem_req  in  1  MEM stage has a load or store pending
- sram_ready  in  1  SRAM controller finished the current access
- if_freeze  out  1  hold the PC and IF/ID
- if_flush  out  1  clear IF/ID
- id_flush  out  1  insert a bubble into ID/EX
- global_freeze  out  1  hold every pipeline register, including the ID/EX Freeze input
- sram_timeout  out  1  sticky: the access exceeded TIMEOUT_CYCLES
- stall_cnt  out  CNT_W  hazard-stall cycles since reset, saturating

## Operation
RAW match, per source s:
- s != 0
- and the match term:
  - s == exe_dst && exe_wb_en
  - or s == mem_dst && mem_wb_en
- Only the src1 match counts when id_two_src = 0.

Hazard condition:
- forward_en = 0: hazard = any RAW match.
- forward_en = 1: hazard = (id_src1 == exe_dst, or id_two_src && id_src2 == exe_dst) && exe_mem_read && exe_wb_en && src != 0. This is load-use only.

SRAM FSM states:
- IDLE: mem_req && !sram_ready → WAIT, with the counter loaded to 1. Otherwise stay in IDLE.
- WAIT:
  - sram_ready → IDLE.
  - Else if counter == TIMEOUT_CYCLES → ERR.
  - Else counter + 1.
- ERR: absorbing until rst. sram_timeout = 1 in this state.

global_freeze = 1 when:
- state = IDLE and mem_req && !sram_ready
- or state = WAIT and !sram_ready
- or state = ERR

Output priority, highest first:
1. global_freeze = 1 → if_freeze = 1, if_flush = 0, id_flush = 0. EX is held, so the branch or hazard is re-evaluated after the freeze ends.
2. branch_taken → if_flush = 1, id_flush = 1, if_freeze = 0.
3. hazard → if_freeze = 1, id_flush = 1, if_flush = 0.
4. Otherwise all three are 0.

stall_cnt increments by 1 in each cycle where case 3 is the active case, and saturates at all-ones.

## Timing
- if_freeze, if_flush, id_flush and global_freeze are combinational from the inputs and the registered state. No added latency: they act at the very next clock edge.
- sram_timeout and stall_cnt are registered.
- Reset values: state IDLE, counter 0, sram_timeout 0, stall_cnt 0. While rst is high, the combinational outputs follow the IDLE-state equations.
- Reset asserted mid-WAIT or in ERR returns the FSM to IDLE immediately and clears the flag.
- sram_ready in the same cycle as mem_req in IDLE: no freeze, the FSM stays in IDLE.
- sram_ready on the cycle the counter equals TIMEOUT_CYCLES: ready wins, → IDLE.
- mem_req dropping during WAIT has no effect; only sram_ready ends WAIT.
- A load-use hazard lasts exactly one cycle. The bubble clears exe_mem_read on the next edge.

## Structure
- hazard_pkg holds:
  - the state enum {IDLE, WAIT, ERR}
  - REG_ZERO = 5'd0
  - the default TIMEOUT_CYCLES
- One sub-module, sram_wait_fsm: FSM, timeout counter, sticky flag and the global_freeze term.
- The hazard comparators, the priority logic and stall_cnt stay in the top level.

## Test plan
- forward_en=0; id_src1=5, exe_dst=5, exe_wb_en=1 → if_freeze=1, id_flush=1, stall_cnt 0→1.
- forward_en=1; same stimulus with exe_mem_read=0 → no stall. With exe_mem_read=1 → one-cycle stall. With id_src1=0 → never a stall.
- id_two_src=0, id_src2=mem_dst=7, mem_wb_en=1, forward_en=0 → no stall. With id_two_src=1 → stall.
- hazard and branch_taken together → if_flush=1, id_flush=1, if_freeze=0.
- mem_req=1, sram_ready low 5 cycles → global_freeze=1 for those 5 cycles and 0 on the ready cycle. A concurrent branch_taken is masked until release.
- sram_ready held low for 16 cycles → sram_timeout=1, freeze stuck. Assert rst mid-ERR → all outputs return to reset values.
